// File: rtl/vx_decode_sched_pkg.sv
// Shared types and sizing for the per-warp decoded-instruction scheduler.
package vx_decode_sched_pkg;

    localparam int unsigned NUM_WARPS = 4;
    localparam int unsigned DEPTH     = 2;
    localparam int unsigned NW_BITS   = $clog2(NUM_WARPS);
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

    // Decode payload; carried opaquely through the scheduler.
    typedef struct packed {
        logic [22:0] uuid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [2:0]  ex_type;
        logic [3:0]  op_type;
        logic [2:0]  op_mod;
        logic        wb;
        logic        use_pc;
        logic        use_imm;
        logic [31:0] imm;
        logic [5:0]  rd;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rs3;
    } decode_payload_t;

    localparam int unsigned PAYLOAD_W = $bits(decode_payload_t);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: first requester at or above i_rr_ptr, wrapping.
module vx_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_rr_ptr,
    output logic [N-1:0]  o_grant_oh,
    output logic [IW-1:0] o_grant_idx
);

    logic          w_found;
    logic [IW-1:0] w_idx;

    // Scan upward from the pointer; index arithmetic wraps in IW bits.
    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = IW'(i_rr_ptr + IW'(k));
            if (!w_found && i_req[w_idx]) begin
                w_found            = 1'b1;
                o_grant_oh[w_idx]  = 1'b1;
                o_grant_idx        = w_idx;
            end
        end
    end

endmodule

// File: rtl/vx_decode_sched.sv
// Per-warp decoded-instruction buffers with round-robin issue selection.
module vx_decode_sched
    import vx_decode_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [NW_BITS-1:0]   in_wid,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 in_ready,
    input  logic [NUM_WARPS-1:0] warp_stall,
    input  logic                 flush_valid,
    input  logic [NW_BITS-1:0]   flush_wid,
    output logic                 out_valid,
    output logic [NW_BITS-1:0]   out_wid,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 out_ready,
    output logic [NUM_WARPS-1:0] pending
);

    logic [PAYLOAD_W-1:0] r_mem    [NUM_WARPS][DEPTH];
    logic [PTR_W-1:0]     r_rd_ptr [NUM_WARPS];
    logic [PTR_W-1:0]     r_wr_ptr [NUM_WARPS];
    logic [CNT_W-1:0]     r_count  [NUM_WARPS];

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [NW_BITS-1:0]   r_locked_wid;
    logic [NW_BITS-1:0]   w_locked_wid_nxt;
    logic [NW_BITS-1:0]   r_rr_ptr;

    logic [NUM_WARPS-1:0] w_flush_oh;
    logic [NUM_WARPS-1:0] w_eligible;
    logic [NUM_WARPS-1:0] w_grant_oh;
    logic [NW_BITS-1:0]   w_grant_idx;
    logic [NW_BITS-1:0]   w_sel_wid;
    logic                 w_out_valid;
    logic                 w_push;
    logic                 w_fire;

    // Flush decode and per-warp eligibility / occupancy.
    always_comb begin
        w_flush_oh = '0;
        w_eligible = '0;
        pending    = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            w_flush_oh[w] = flush_valid && (flush_wid == NW_BITS'(w));
            pending[w]    = (r_count[w] != '0);
            w_eligible[w] = pending[w] && !warp_stall[w] && !w_flush_oh[w];
        end
    end

    // Space check ignores out_ready so a pop never frees a slot same-cycle.
    assign in_ready = (r_count[in_wid] != CNT_W'(DEPTH)) && !w_flush_oh[in_wid];
    assign w_push   = in_valid && in_ready;

    vx_rr_arbiter #(
        .N  (NUM_WARPS),
        .IW (NW_BITS)
    ) u_rr_arbiter (
        .i_req       (w_eligible),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx)
    );

    // Output selection: fresh arbitration when idle, held warp when locked.
    always_comb begin
        w_sel_wid   = w_grant_idx;
        w_out_valid = |w_grant_oh;
        if (r_state == LOCKED) begin
            w_sel_wid   = r_locked_wid;
            w_out_valid = !w_flush_oh[r_locked_wid];
        end
        out_valid = w_out_valid;
        out_wid   = w_out_valid ? w_sel_wid : '0;
        out_data  = w_out_valid ? r_mem[w_sel_wid][r_rd_ptr[w_sel_wid]] : '0;
    end

    assign w_fire = w_out_valid && out_ready;

    // Lock on a stalled presentation; release on fire or flush of the held warp.
    always_comb begin
        w_state_nxt      = r_state;
        w_locked_wid_nxt = r_locked_wid;
        case (r_state)
            IDLE: begin
                if (w_out_valid && !out_ready) begin
                    w_state_nxt      = LOCKED;
                    w_locked_wid_nxt = w_sel_wid;
                end
            end
            LOCKED: begin
                if (!w_out_valid || out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Arbiter state, held warp and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_locked_wid <= '0;
            r_rr_ptr     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_locked_wid <= w_locked_wid_nxt;
            if (w_fire) begin
                r_rr_ptr <= w_sel_wid + NW_BITS'(1);
            end
        end
    end

    // Per-warp pointers and counts; flush wins over push and pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                r_rd_ptr[w] <= '0;
                r_wr_ptr[w] <= '0;
                r_count[w]  <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                if (w_flush_oh[w]) begin
                    r_rd_ptr[w] <= '0;
                    r_wr_ptr[w] <= '0;
                    r_count[w]  <= '0;
                end else begin
                    if (w_push && (in_wid == NW_BITS'(w))) begin
                        r_wr_ptr[w] <= r_wr_ptr[w] + PTR_W'(1);
                    end
                    if (w_fire && (w_sel_wid == NW_BITS'(w))) begin
                        r_rd_ptr[w] <= r_rd_ptr[w] + PTR_W'(1);
                    end
                    case ({w_push && (in_wid == NW_BITS'(w)), w_fire && (w_sel_wid == NW_BITS'(w))})
                        2'b10:   r_count[w] <= r_count[w] + CNT_W'(1);
                        2'b01:   r_count[w] <= r_count[w] - CNT_W'(1);
                        default: r_count[w] <= r_count[w];
                    endcase
                end
            end
        end
    end

    // Payload storage; contents are qualified by the counts, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[in_wid][r_wr_ptr[in_wid]] <= in_data;
        end
    end

endmodule
